// File: rtl/wb_sram16_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-16-bit asynchronous SRAM controller:
// FSM encoding, half-word select and byte-enable helper.
package wb_sram16_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_HI     = 3'd1,
        RD_LO     = 3'd2,
        WR_HI     = 3'd3,
        WR_GAP_HI = 3'd4,
        WR_LO     = 3'd5,
        WR_GAP_LO = 3'd6,
        ACK       = 3'd7
    } state_t;

    // SRAM word address LSB selecting which 16-bit half of the 32-bit word
    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    // Big-endian sel pair {upper, lower} to active-low {ub_n, lb_n}
    function automatic logic [1:0] sel_to_be_n(input logic [1:0] sel_pair);
        return ~sel_pair;
    endfunction

endpackage

// File: rtl/wb_sram16_ctrl_if.sv
// Wishbone classic slave bus between the system interconnect and the SRAM controller.
interface wb_sram16_ctrl_if;
    // Handshake: the master asserts cyc&stb with adr/dat/sel/we stable until the
    // slave answers with a single-cycle ack; dat_o is only meaningful while ack=1.
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sram16_ctrl.sv
// Wishbone classic slave splitting each 32-bit access into two 16-bit phases on an
// asynchronous SRAM, with programmable strobe width and write-recovery gaps.
module wb_sram16_ctrl
    import wb_sram16_pkg::*;
#(
    parameter int adr_width   = 18,
    parameter int wait_cycles = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    wb_sram16_ctrl_if.slave      wb,
    output logic [adr_width-1:0] sram_adr,
    inout  wire  [15:0]          sram_dat,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output state_t               dbg_state
);

    localparam logic [3:0] WAIT_LOAD = 4'(wait_cycles - 1);

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic phase_done, phase_entry, accept;

    logic [adr_width-2:0] adr_q, src_adr;
    logic [3:0]  sel_q, src_sel;
    logic [31:0] wdat_q, src_dat, rdat_q;

    logic [adr_width-1:0] adr_d;
    logic [15:0] dout_q, dout_d;
    logic drive_q, drive_d;
    logic ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;

    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb.wb_adr_i[31:adr_width+1], wb.wb_adr_i[1:0]};

    assign accept      = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign phase_done  = (wait_cnt == 4'd0);
    assign phase_entry = (state_nxt != state) &&
                         (state_nxt inside {RD_HI, RD_LO, WR_HI, WR_LO});

    // The request is still on the bus during the accept edge; afterwards use the latched copy
    assign src_adr = (state == IDLE) ? wb.wb_adr_i[adr_width:2] : adr_q;
    assign src_sel = (state == IDLE) ? wb.wb_sel_i : sel_q;
    assign src_dat = (state == IDLE) ? wb.wb_dat_i : wdat_q;

    assign wb.wb_ack_o = (state == ACK) & wb.wb_cyc_i;
    assign wb.wb_dat_o = rdat_q;
    assign dbg_state   = state;
    assign sram_dat    = drive_q ? dout_q : 16'hzzzz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!wb.wb_we_i)             state_nxt = RD_HI;
                    else if (|wb.wb_sel_i[3:2])  state_nxt = WR_HI;
                    else if (|wb.wb_sel_i[1:0])  state_nxt = WR_LO;
                    else                         state_nxt = ACK;
                end
            end
            RD_HI:     if (phase_done) state_nxt = RD_LO;
            RD_LO:     if (phase_done) state_nxt = ACK;
            WR_HI:     if (phase_done) state_nxt = WR_GAP_HI;
            WR_GAP_HI: state_nxt = (|sel_q[1:0]) ? WR_LO : ACK;
            WR_LO:     if (phase_done) state_nxt = WR_GAP_LO;
            WR_GAP_LO: state_nxt = ACK;
            ACK:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (phase_entry)
            wait_cnt_nxt = WAIT_LOAD;
        else if (wait_cnt != 4'd0)
            wait_cnt_nxt = wait_cnt - 4'd1;
    end

    // Pin values for the coming cycle, registered below so every SRAM control is a flop
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        drive_d = 1'b0;
        adr_d   = sram_adr;
        dout_d  = dout_q;
        case (state_nxt)
            RD_HI, RD_LO: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
                adr_d  = {src_adr, (state_nxt == RD_LO) ? HALF_LO : HALF_HI};
            end
            WR_HI, WR_GAP_HI: begin
                ce_n_d             = 1'b0;
                we_n_d             = (state_nxt != WR_HI);
                {ub_n_d, lb_n_d}   = sel_to_be_n(src_sel[3:2]);
                drive_d            = 1'b1;
                adr_d              = {src_adr, HALF_HI};
                dout_d             = src_dat[31:16];
            end
            WR_LO, WR_GAP_LO: begin
                ce_n_d             = 1'b0;
                we_n_d             = (state_nxt != WR_LO);
                {ub_n_d, lb_n_d}   = sel_to_be_n(src_sel[1:0]);
                drive_d            = 1'b1;
                adr_d              = {src_adr, HALF_LO};
                dout_d             = src_dat[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_adr  <= '0;
            drive_q   <= 1'b0;
            dout_q    <= 16'd0;
        end else begin
            sram_ce_n <= ce_n_d;
            sram_oe_n <= oe_n_d;
            sram_we_n <= we_n_d;
            sram_ub_n <= ub_n_d;
            sram_lb_n <= lb_n_d;
            sram_adr  <= adr_d;
            drive_q   <= drive_d;
            dout_q    <= dout_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adr_q  <= '0;
            sel_q  <= 4'd0;
            wdat_q <= 32'd0;
        end else if (state == IDLE && accept) begin
            adr_q  <= wb.wb_adr_i[adr_width:2];
            sel_q  <= wb.wb_sel_i;
            wdat_q <= wb.wb_dat_i;
        end
    end

    // Read data is taken on the last edge of each phase, after the full access time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdat_q <= 32'd0;
        end else begin
            if (state == RD_HI && phase_done) rdat_q[31:16] <= sram_dat;
            if (state == RD_LO && phase_done) rdat_q[15:0]  <= sram_dat;
        end
    end

endmodule

// File: tb/tb_wb_sram16_ctrl.sv
// Self-checking bench for wb_sram16_ctrl: directed bus scenarios plus randomized
// traffic checked against a word-array reference model of the SRAM contents.
module tb_wb_sram16_ctrl;
    import wb_sram16_pkg::*;

    localparam int W     = 2;
    localparam int AW    = 18;
    localparam int NWORD = 1 << AW;

    logic clk;
    logic reset_n;
    logic [AW-1:0] sram_adr;
    wire  [15:0] sram_dat;
    logic sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;
    state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    wb_sram16_ctrl_if wb ();

    wb_sram16_ctrl #(.adr_width(AW), .wait_cycles(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb        (wb),
        .sram_adr  (sram_adr),
        .sram_dat  (sram_dat),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- asynchronous SRAM device model ----------------
    pullup (sram_dat);
    logic [15:0] sram_mem [0:NWORD-1];
    assign sram_dat = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_adr] : 16'hzzzz;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 40503) ^ 16'h5A5A);
    endfunction

    initial begin
        for (int i = 0; i < NWORD; i++) sram_mem[i] = init_word(i);
        forever begin
            @(posedge sram_we_n);
            if (reset_n && !sram_ce_n) begin
                if (!sram_ub_n) sram_mem[sram_adr][15:8] = sram_dat[15:8];
                if (!sram_lb_n) sram_mem[sram_adr][7:0]  = sram_dat[7:0];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:NWORD-1];

    function automatic int word_of(input logic [31:0] a);
        return int'(a[AW:2]) * 2;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int wi = word_of(a);
        return {ref_mem[wi], ref_mem[wi+1]};
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int wi = word_of(a);
        if (s[3]) ref_mem[wi][15:8]   = d[31:24];
        if (s[2]) ref_mem[wi][7:0]    = d[23:16];
        if (s[1]) ref_mem[wi+1][15:8] = d[15:8];
        if (s[0]) ref_mem[wi+1][7:0]  = d[7:0];
    endfunction

    // Cycle after the accept edge in which ack is expected
    function automatic int exp_lat(input logic we, input logic [3:0] s);
        int halves;
        if (!we) return 2 * W + 1;
        halves = int'(|s[3:2]) + int'(|s[1:0]);
        return (halves == 0) ? 1 : halves * (W + 1) + 1;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- per-cycle trace of one transfer ----------------
    logic [31:0]   tr_we, tr_oe, tr_ce, tr_ub, tr_lb;
    logic [AW-1:0] tr_adr [0:31];

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        @(posedge clk);
        lat  = 0;
        rdat = 32'd0;
        tr_we = '1; tr_oe = '1; tr_ce = '1; tr_ub = '1; tr_lb = '1;
        for (int c = 1; c <= 31 && lat == 0; c++) begin
            @(negedge clk);
            tr_we[c]  = sram_we_n;
            tr_oe[c]  = sram_oe_n;
            tr_ce[c]  = sram_ce_n;
            tr_ub[c]  = sram_ub_n;
            tr_lb[c]  = sram_lb_n;
            tr_adr[c] = sram_adr;
            if (wb.wb_ack_o) begin
                lat  = c;
                rdat = wb.wb_dat_o;
            end
        end
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    logic [31:0] rd, rd2;
    int lat, gap;
    logic seen_ack;
    state_t st_seen;

    initial begin
        for (int i = 0; i < NWORD; i++) ref_mem[i] = init_word(i);
        reset_n     = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 32'd0;
        wb.wb_dat_i = 32'd0;
        wb.wb_sel_i = 4'd0;

        // Reset held with the clock running
        repeat (3) @(negedge clk);
        check("rst_ctrl", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_adr", 32'(sram_adr), 32'd0);
        check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        check("rst_dat_o", wb.wb_dat_o, 32'd0);
        check("rst_bus_z", 32'(sram_dat), 32'h0000FFFF);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_idle_ctrl", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_idle_ack", 32'(wb.wb_ack_o), 32'd0);
        #1 reset_n = 1'b1;

        // Full write 0xDEADBEEF at 0x100
        wb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, lat);
        ref_write(32'h100, 32'hDEADBEEF, 4'hF);
        check("fw_lat", 32'(lat), 32'd7);
        check("fw_we_pattern", tr_we, 32'hFFFF_FFC9);
        check("fw_adr_hi_c1", 32'(tr_adr[1]), 32'h80);
        check("fw_adr_hi_c2", 32'(tr_adr[2]), 32'h80);
        check("fw_adr_lo_c4", 32'(tr_adr[4]), 32'h81);
        check("fw_adr_lo_c5", 32'(tr_adr[5]), 32'h81);
        check("fw_mem_hi", 32'(sram_mem[32'h80]), 32'hDEAD);
        check("fw_mem_lo", 32'(sram_mem[32'h81]), 32'hBEEF);

        // Read back
        wb_xfer(1'b0, 32'h100, 32'h0, 4'hF, rd, lat);
        check("rd_lat", 32'(lat), 32'd5);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_oe_pattern", tr_oe, 32'hFFFF_FFE1);
        check("rd_no_we", tr_we, 32'hFFFF_FFFF);
        check("rd_be_hi", {30'd0, tr_ub[1], tr_lb[1]}, 32'd0);
        check("rd_be_lo", {30'd0, tr_ub[3], tr_lb[3]}, 32'd0);
        check("rd_adr_lo", 32'(tr_adr[3]), 32'h81);

        // Single byte write into the upper half
        wb_xfer(1'b1, 32'h100, 32'h00AA0000, 4'b0100, rd, lat);
        ref_write(32'h100, 32'h00AA0000, 4'b0100);
        check("bw_lat", 32'(lat), 32'd4);
        check("bw_we_pattern", tr_we, 32'hFFFF_FFF9);
        check("bw_ce_pattern", tr_ce, 32'hFFFF_FFF1);
        check("bw_be", {30'd0, tr_ub[1], tr_lb[1]}, 32'h2);
        check("bw_adr_gap", 32'(tr_adr[3]), 32'h80);
        check("bw_mem_lo_untouched", 32'(sram_mem[32'h81]), 32'hBEEF);
        wb_xfer(1'b0, 32'h100, 32'h0, 4'hF, rd, lat);
        check("bw_readback", rd, 32'hDEAABEEF);

        // Reset in the middle of a write strobe
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = 32'h300; wb.wb_dat_i = 32'h12345678; wb.wb_sel_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("mw_we_active", 32'(sram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1 check("mw_we_released", 32'(sram_we_n), 32'd1);
        check("mw_bus_z", 32'(sram_dat), 32'h0000FFFF);
        check("mw_ack", 32'(wb.wb_ack_o), 32'd0);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mw_ack_held", 32'(wb.wb_ack_o), 32'd0);
        #2 reset_n = 1'b1;
        wb_xfer(1'b0, 32'h200, 32'h0, 4'hF, rd, lat);
        check("mw_rd_lat", 32'(lat), 32'd5);
        check("mw_rd_data", rd, ref_read(32'h200));

        // Back-to-back reads with stb held
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 32'h100; wb.wb_sel_i = 4'hF;
        @(posedge clk);
        lat = 0; rd = 32'd0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if (wb.wb_ack_o) begin lat = c; rd = wb.wb_dat_o; end
        end
        @(posedge clk); #1;
        wb.wb_adr_i = 32'h200;
        gap = 0; rd2 = 32'd0;
        for (int c = 1; c <= 30 && gap == 0; c++) begin
            @(negedge clk);
            if (wb.wb_ack_o) begin gap = c; rd2 = wb.wb_dat_o; end
        end
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        check("b2b_lat1", 32'(lat), 32'd5);
        check("b2b_data1", rd, ref_read(32'h100));
        check("b2b_gap", 32'(gap), 32'd6);
        check("b2b_data2", rd2, ref_read(32'h200));

        // Abort: cyc dropped during the low read phase
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 32'h400;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("ab_in_rd_lo", 32'(dbg_state), 32'(RD_LO));
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        seen_ack = 1'b0;
        st_seen  = ACK;
        for (int c = 4; c <= 12; c++) begin
            @(negedge clk);
            if (wb.wb_ack_o) seen_ack = 1'b1;
            if (c == 6) st_seen = dbg_state;
        end
        check("ab_no_ack", 32'(seen_ack), 32'd0);
        check("ab_idle", 32'(st_seen), 32'(IDLE));

        // Randomized traffic over a small window so reads hit earlier writes
        for (int n = 0; n < 60; n++) begin
            logic        r_we;
            logic [31:0] r_adr, r_dat;
            logic [3:0]  r_sel;
            r_we  = 1'($urandom_range(0, 1));
            r_adr = 32'h400 + 32'($urandom_range(0, 15)) * 4;
            r_sel = 4'($urandom_range(0, 15));
            r_dat = $urandom;
            wb_xfer(r_we, r_adr, r_dat, r_sel, rd, lat);
            check("rnd_lat", 32'(lat), 32'(exp_lat(r_we, r_sel)));
            if (r_we) ref_write(r_adr, r_dat, r_sel);
            else      check("rnd_rdata", rd, ref_read(r_adr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
